fetch_pc_unit: RTL and testbench

- Upstream stage of the byte-addressed instruction memory.
- Owns the program counter, selects the next PC (sequential, branch, jump, jump-register) and drives `pc` into the memory.
- Registers the returned 32-bit instruction into an IF/ID pipeline register with valid, stall and flush control.
- Branch, jump and jr are resolved in ID using the IF/ID contents.

---
 rtl/mips_pkg.sv | 18 +
 rtl/fetch_pc_unit_if.sv | 29 ++
 rtl/next_pc_sel.sv | 40 ++++
 rtl/fetch_pc_unit.sv | 100 ++++++++++
 tb/tb_fetch_pc_unit.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch-stage types and constants (FSM state, NOP, PC step, field widths, address wrap helper).
// Optional feature macro ALIGN_CHECK_EN adds the FAULT state.
package mips_pkg;
  typedef logic [1:0] state_t;
  localparam state_t BOOT = 2'd0;
  localparam state_t RUN  = 2'd1;
`ifdef ALIGN_CHECK_EN
  localparam state_t FAULT = 2'd2;
`endif
  localparam logic [31:0] NOP     = 32'h0000_0000;
  localparam logic [31:0] PC_STEP = 32'd4;
  localparam int IMM_W   = 16;
  localparam int JADDR_W = 26;
  // Keep only the implemented address bits; upper PC bits always read 0.
  function automatic logic [31:0] wrap_addr(input logic [31:0] a, input int bits);
    return a & 32'((64'd1 << bits) - 64'd1);
  endfunction
endpackage

// File: rtl/fetch_pc_unit_if.sv
// fetch_pc_unit_if: fetch-stage bundle between the PC unit, instruction memory and the ID stage.
// Ports: stall, flush, branch_taken/branch_offset, jump/jump_address, jr/jr_target, instruction_in (into fetch);
//        pc, if_id_instruction, if_id_pc_plus4, if_id_valid, fetch_fault (out of fetch).
// master = fetch unit, slave = surrounding pipeline/memory.
interface fetch_pc_unit_if;
  import mips_pkg::*;
  logic               stall;
  logic               flush;
  logic               branch_taken;
  logic [IMM_W-1:0]   branch_offset;
  logic               jump;
  logic [JADDR_W-1:0] jump_address;
  logic               jr;
  logic [31:0]        jr_target;
  logic [31:0]        instruction_in;
  logic [31:0]        pc;
  logic [31:0]        if_id_instruction;
  logic [31:0]        if_id_pc_plus4;
  logic               if_id_valid;
  logic               fetch_fault;
  modport master (
    input  stall, flush, branch_taken, branch_offset, jump, jump_address, jr, jr_target, instruction_in,
    output pc, if_id_instruction, if_id_pc_plus4, if_id_valid, fetch_fault
  );
  modport slave (
    output stall, flush, branch_taken, branch_offset, jump, jump_address, jr, jr_target, instruction_in,
    input  pc, if_id_instruction, if_id_pc_plus4, if_id_valid, fetch_fault
  );
endinterface

// File: rtl/next_pc_sel.sv
// next_pc_sel: combinational redirect target computation and jr > jump > branch > sequential priority mux.
// Inputs: pc, IF/ID pc_plus4/valid, redirect requests and their fields. Outputs: next_pc, redirect,
// misaligned (ALIGN_CHECK_EN only: selected target has nonzero low bits).
module next_pc_sel
  import mips_pkg::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic [31:0]        pc,
  input  logic [31:0]        if_id_pc_plus4,
  input  logic               if_id_valid,
  input  logic               branch_taken,
  input  logic [IMM_W-1:0]   branch_offset,
  input  logic               jump,
  input  logic [JADDR_W-1:0] jump_address,
  input  logic               jr,
  input  logic [31:0]        jr_target,
`ifdef ALIGN_CHECK_EN
  output logic               misaligned,
`endif
  output logic [31:0]        next_pc,
  output logic               redirect
);
  logic [31:0] seq_pc, br_tgt, j_tgt, sel_tgt, tgt;
  always_comb begin
    seq_pc   = wrap_addr(pc + PC_STEP, ADDR_BITS);
    br_tgt   = if_id_pc_plus4 + {{(32-IMM_W-2){branch_offset[IMM_W-1]}}, branch_offset, 2'b00};
    j_tgt    = {if_id_pc_plus4[31:28], jump_address, 2'b00};
    sel_tgt  = jr ? jr_target : jump ? j_tgt : br_tgt;
    // Redirect fields come from ID; they mean nothing unless IF/ID holds a real instruction.
    redirect = if_id_valid & (jr | jump | branch_taken);
`ifdef ALIGN_CHECK_EN
    misaligned = redirect & (|sel_tgt[1:0]);
    tgt        = wrap_addr(sel_tgt, ADDR_BITS);
`else
    tgt        = wrap_addr(sel_tgt & ~32'h3, ADDR_BITS);
`endif
    next_pc  = redirect ? tgt : seq_pc;
  end
endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: program counter, next-PC selection and IF/ID pipeline register with stall/flush.
// Ports: clk, rst_n (async active-low), bus (fetch_pc_unit_if.master: redirect inputs, instruction_in,
// pc, IF/ID outputs, fetch_fault). Optional macro ALIGN_CHECK_EN: misaligned redirect -> sticky FAULT.
module fetch_pc_unit
  import mips_pkg::*;
#(
  parameter int          ADDR_BITS = 8,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  fetch_pc_unit_if.master bus
);
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, inst_q, inst_d, pp4_q, pp4_d, next_pc, seq_pc;
  logic        valid_q, valid_d, redirect, bubble;
`ifdef ALIGN_CHECK_EN
  logic        fault_q, fault_d, misaligned;
`endif
  next_pc_sel #(.ADDR_BITS(ADDR_BITS)) u_sel (
    .pc             (pc_q),
    .if_id_pc_plus4 (pp4_q),
    .if_id_valid    (valid_q),
    .branch_taken   (bus.branch_taken),
    .branch_offset  (bus.branch_offset),
    .jump           (bus.jump),
    .jump_address   (bus.jump_address),
    .jr             (bus.jr),
    .jr_target      (bus.jr_target),
`ifdef ALIGN_CHECK_EN
    .misaligned     (misaligned),
`endif
    .next_pc        (next_pc),
    .redirect       (redirect)
  );
  always_comb begin
    seq_pc  = wrap_addr(pc_q + PC_STEP, ADDR_BITS);
    // The word fetched alongside a redirect is wrong-path; a flush kills it too.
    bubble  = redirect | bus.flush;
    pc_d    = pc_q;
    inst_d  = inst_q;
    pp4_d   = pp4_q;
    valid_d = valid_q;
    state_d = state_q;
`ifdef ALIGN_CHECK_EN
    fault_d = fault_q;
`endif
    if (state_q == BOOT) begin
      inst_d  = bus.instruction_in;
      pp4_d   = seq_pc;
      valid_d = 1'b1;
      state_d = RUN;
`ifdef ALIGN_CHECK_EN
    end else if (state_q == FAULT) begin
      inst_d  = NOP;
      valid_d = 1'b0;
    end else if (!bus.stall && misaligned) begin
      inst_d  = NOP;
      valid_d = 1'b0;
      fault_d = 1'b1;
      state_d = FAULT;
`endif
    end else if (!bus.stall) begin
      pc_d    = next_pc;
      pp4_d   = seq_pc;
      inst_d  = bubble ? NOP : bus.instruction_in;
      valid_d = !bubble;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= wrap_addr(RESET_PC, ADDR_BITS);
      inst_q  <= NOP;
      pp4_q   <= '0;
      valid_q <= 1'b0;
`ifdef ALIGN_CHECK_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      pp4_q   <= pp4_d;
      valid_q <= valid_d;
`ifdef ALIGN_CHECK_EN
      fault_q <= fault_d;
`endif
    end
  end
  assign bus.pc                = pc_q;
  assign bus.if_id_instruction = inst_q;
  assign bus.if_id_pc_plus4    = pp4_q;
  assign bus.if_id_valid       = valid_q;
`ifdef ALIGN_CHECK_EN
  assign bus.fetch_fault       = fault_q;
`else
  assign bus.fetch_fault       = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed plus randomized checks of fetch_pc_unit against an integer reference model.
module tb_fetch_pc_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int m_pc, m_pp4;
  logic [31:0] m_inst;
  bit m_valid, m_boot, m_fault;
  fetch_pc_unit_if bus ();
  fetch_pc_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic idle_inputs();
    bus.stall = 0; bus.flush = 0; bus.branch_taken = 0; bus.branch_offset = '0;
    bus.jump = 0; bus.jump_address = '0; bus.jr = 0; bus.jr_target = '0;
  endtask
  task automatic model_reset();
    m_pc = 0; m_pp4 = 0; m_inst = '0; m_valid = 0; m_boot = 1; m_fault = 0;
  endtask
  // Reference: PC is an integer modulo 256, redirects chosen by priority from the held IF/ID state.
  task automatic model_update();
    int t;
    bit rd;
    if (m_boot) begin
      m_inst = bus.instruction_in; m_pp4 = (m_pc + 4) & 255; m_valid = 1; m_boot = 0;
    end else if (m_fault) begin
      m_inst = '0; m_valid = 0;
    end else if (!bus.stall) begin
      rd = m_valid && (bus.jr || bus.jump || bus.branch_taken);
      if (bus.jr) t = int'(bus.jr_target & 32'hFF);
      else if (bus.jump) t = (int'(bus.jump_address) * 4) & 255;
      else t = (m_pp4 + 4 * int'($signed(bus.branch_offset))) & 255;
`ifdef ALIGN_CHECK_EN
      if (rd && (t % 4) != 0) begin
        m_fault = 1; m_inst = '0; m_valid = 0;
        return;
      end
`else
      t = t & 252;
`endif
      m_pp4 = (m_pc + 4) & 255;
      m_pc = rd ? t : (m_pc + 4) & 255;
      if (rd || bus.flush) begin m_inst = '0; m_valid = 0; end
      else begin m_inst = bus.instruction_in; m_valid = 1; end
    end
  endtask
  task automatic check_model();
    chk("pc", bus.pc, 32'(m_pc));
    chk("if_id_valid", {31'd0, bus.if_id_valid}, {31'd0, m_valid});
    chk("if_id_instruction", bus.if_id_instruction, m_inst);
    if (m_valid) chk("if_id_pc_plus4", bus.if_id_pc_plus4, 32'(m_pp4));
    chk("fetch_fault", {31'd0, bus.fetch_fault}, {31'd0, m_fault});
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    model_update();
    check_model();
  endtask
  task automatic apply_reset();
    rst_n = 0;
    #2;
    model_reset();
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_inst", bus.if_id_instruction, 32'h0);
    chk("rst_pp4", bus.if_id_pc_plus4, 32'h0);
    chk("rst_valid", {31'd0, bus.if_id_valid}, 32'h0);
    chk("rst_fault", {31'd0, bus.fetch_fault}, 32'h0);
    @(negedge clk);
    rst_n = 1;
  endtask
  initial begin
    idle_inputs();
    bus.instruction_in = 32'h2008_0005;
    apply_reset();
    step();
    chk("boot_valid", {31'd0, bus.if_id_valid}, 32'h1);
    chk("boot_inst", bus.if_id_instruction, 32'h2008_0005);
    chk("boot_pp4", bus.if_id_pc_plus4, 32'h4);
    chk("boot_pc", bus.pc, 32'h0);
    step();
    chk("seq_pc4", bus.pc, 32'h4);
    bus.instruction_in = 32'h1111_0004;
    step();
    chk("seq_pc8", bus.pc, 32'h8);
    chk("seq_pp4_8", bus.if_id_pc_plus4, 32'h8);
    bus.branch_taken = 1; bus.branch_offset = 16'hFFFE; bus.instruction_in = 32'hDEAD_0008;
    step();
    chk("br_pc", bus.pc, 32'h0);
    chk("br_bubble", {31'd0, bus.if_id_valid}, 32'h0);
    idle_inputs(); bus.instruction_in = 32'h2222_0000;
    step();
    chk("br_refetch_inst", bus.if_id_instruction, 32'h2222_0000);
    chk("br_refetch_pc", bus.pc, 32'h4);
    bus.jump = 1; bus.jump_address = 26'h0000010; bus.jr = 1; bus.jr_target = 32'h0000_0080;
    step();
    chk("jr_wins_pc", bus.pc, 32'h80);
    chk("jr_bubble", {31'd0, bus.if_id_valid}, 32'h0);
    idle_inputs(); bus.instruction_in = 32'h3333_0080;
    step();
    bus.stall = 1; bus.branch_taken = 1; bus.branch_offset = 16'h0004; bus.instruction_in = 32'h4444_0084;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", bus.pc, 32'h84);
      chk("stall_inst", bus.if_id_instruction, 32'h3333_0080);
    end
    bus.stall = 0;
    step();
    chk("post_stall_br", bus.pc, 32'h94);
    idle_inputs();
    step();
    bus.jr = 1; bus.jr_target = 32'h0000_00FC;
    step();
    chk("jr_fc", bus.pc, 32'hFC);
    idle_inputs(); bus.instruction_in = 32'h5555_00FC;
    step();
    chk("wrap_pc", bus.pc, 32'h0);
    chk("wrap_pp4", bus.if_id_pc_plus4, 32'h0);
    bus.flush = 1;
    step();
    chk("flush_pc", bus.pc, 32'h4);
    chk("flush_valid", {31'd0, bus.if_id_valid}, 32'h0);
    idle_inputs();
    for (int i = 0; i < 300; i++) begin
      bus.instruction_in = $urandom;
      bus.stall = ($urandom % 4) == 0;
      bus.flush = ($urandom % 10) == 0;
      bus.jr = ($urandom % 7) == 0;
      bus.jump = ($urandom % 6) == 0;
      bus.branch_taken = ($urandom % 4) == 0;
      bus.branch_offset = 16'($urandom);
      bus.jump_address = 26'($urandom);
      bus.jr_target = (($urandom % 20) == 0) ? $urandom : ($urandom & ~32'h3);
      step();
    end
    idle_inputs();
    @(posedge clk);
    #1;
    apply_reset();
    step();
    step();
    bus.jr = 1; bus.jr_target = 32'h0000_0042;
    step();
`ifdef ALIGN_CHECK_EN
    chk("align_fault", {31'd0, bus.fetch_fault}, 32'h1);
    chk("align_pc_hold", bus.pc, 32'h4);
`else
    chk("align_forced_pc", bus.pc, 32'h40);
`endif
    chk("align_bubble", {31'd0, bus.if_id_valid}, 32'h0);
    idle_inputs();
    step();
    step();
    @(posedge clk);
    #1;
    apply_reset();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
